// File: rtl/spi_word_target.sv
// +----------------------------------------------------------------------------+
// | spi_word_target: mode-0 SPI target that moves WIDTH-bit words between the  |
// | SPI pins and a clk_sys_i receive FIFO / transmit holding register.         |
// | Optional macro: SPI_WORD_TARGET_ECHO_EN (fill word = last received word). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module spi_word_target #(
  parameter int WIDTH    = 8,
  parameter int RX_DEPTH = 4
) (
  input  logic             clk_sys_i,
  input  logic             reset_i,
  input  logic             spi_sck_i,
  input  logic             spi_cs_ni,
  input  logic             spi_rx_i,
  output logic             spi_tx_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic             rx_overflow_o
);

  localparam int c_cw = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_aw = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [c_cw-1:0] c_last  = c_cw'(WIDTH - 1);
  localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(RX_DEPTH);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_armed = 2'd1;
  localparam logic [1:0] c_st_skip  = 2'd2;

  // [0],[1] synchronizer, [2] edge-detect delay
  logic [2:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic [1:0] r_settle;
  logic [1:0] r_state, w_next;

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_cs_low, w_mosi;
  logic w_first, w_settled, w_armed, w_start, w_end;

  logic [WIDTH-2:0] r_rx_sr;
  logic [WIDTH-1:0] w_rx_next;
  logic [c_cw-1:0]  r_rx_cnt, r_tx_cnt;
  logic [WIDTH-1:0] r_tx_sr, r_hold, w_fill, w_load_word;
  logic             r_hold_full, w_tx_load, w_push;

  logic [WIDTH-1:0] r_mem [RX_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_full, w_pop, w_wr;
  logic             r_overflow, r_frame_start, r_frame_end;

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      r_sck_sync  <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 3'b000;
      r_settle    <= 2'd0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], spi_sck_i};
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs_ni};
      r_mosi_sync <= {r_mosi_sync[1:0], spi_rx_i};
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
    end
  end

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_cs_low   = ~r_cs_sync[1];
  assign w_mosi     = r_mosi_sync[2];
  // Synchronizer carries its first post-reset CS sample when r_settle == 2;
  // a low CS there means we joined a frame already in progress.
  assign w_first    = (r_settle == 2'd2);
  assign w_settled  = (r_settle == 2'd3);

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) r_state <= c_st_idle;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_first && w_cs_low)        w_next = c_st_skip;
        else if (w_settled && w_cs_fall) w_next = c_st_armed;
      end
      c_st_armed: if (w_cs_rise) w_next = c_st_idle;
      c_st_skip:  if (w_cs_rise) w_next = c_st_idle;
      default:    w_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_armed  = (r_state == c_st_armed);
    w_start  = (r_state == c_st_idle) && (w_next == c_st_armed);
    w_end    = (r_state != c_st_idle) && w_cs_rise;
    spi_tx_o = w_armed & w_cs_low & r_tx_sr[WIDTH-1];
  end

`ifdef SPI_WORD_TARGET_ECHO_EN
  logic [WIDTH-1:0] r_echo;
  always_ff @(posedge clk_sys_i) begin
    if (reset_i)   r_echo <= '0;
    else if (w_wr) r_echo <= w_rx_next;
  end
  assign w_fill = r_echo;
`else
  assign w_fill = '0;
`endif

  assign w_rx_next   = {r_rx_sr, w_mosi};
  assign w_push      = w_armed & w_sck_rise & (r_rx_cnt == c_last);
  assign w_tx_load   = w_start | (w_armed & w_sck_fall & (r_tx_cnt == c_last));
  assign w_load_word = r_hold_full ? r_hold : w_fill;

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      r_rx_sr       <= '0;
      r_rx_cnt      <= '0;
      r_tx_cnt      <= '0;
      r_tx_sr       <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
    end else begin
      r_frame_start <= w_start;
      r_frame_end   <= w_end;
      if (w_start) begin
        r_rx_cnt <= '0;
        r_tx_cnt <= '0;
        r_tx_sr  <= w_load_word;
      end else if (w_armed) begin
        if (w_sck_rise) begin
          r_rx_sr  <= w_rx_next[WIDTH-2:0];
          r_rx_cnt <= (r_rx_cnt == c_last) ? '0 : r_rx_cnt + c_cw'(1);
        end
        if (w_sck_fall) begin
          if (r_tx_cnt == c_last) begin
            r_tx_sr  <= w_load_word;
            r_tx_cnt <= '0;
          end else begin
            r_tx_sr  <= {r_tx_sr[WIDTH-2:0], 1'b0};
            r_tx_cnt <= r_tx_cnt + c_cw'(1);
          end
        end
      end
      if (w_tx_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (tx_valid_i && !r_hold_full) begin
        r_hold      <= tx_data_i;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign w_full = (r_count == c_depth);
  assign w_pop  = (r_count != '0) & rx_ready_i;
  // A pop in the same cycle makes room, so a full FIFO still accepts the word.
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_aw'(1);
      r_count <= r_count + {{c_aw{1'b0}}, w_wr} - {{c_aw{1'b0}}, w_pop};
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_rx_next;
  end

  assign rx_valid_o    = (r_count != '0);
  assign rx_data_o     = rx_valid_o ? r_mem[r_rd_ptr] : '0;
  assign tx_ready_o    = ~r_hold_full;
  assign frame_start_o = r_frame_start;
  assign frame_end_o   = r_frame_end;
  assign rx_overflow_o = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_spi_word_target.sv
// +----------------------------------------------------------------------------+
// | tb_spi_word_target: self-checking bench for spi_word_target (8- and 16-bit)|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_spi_word_target;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sck, cs_n, mosi;
  logic miso8, rx_valid8, rx_ready8, tx_valid8, tx_ready8, fs8, fe8, ovf8;
  logic [7:0] rx_data8, tx_data8;
  logic miso16, rx_valid16, tx_valid16, tx_ready16, fs16, fe16, ovf16;
  logic [15:0] rx_data16, tx_data16;

  spi_word_target #(.WIDTH(8), .RX_DEPTH(4)) u_dut8 (
    .clk_sys_i(clk), .reset_i(rst), .spi_sck_i(sck), .spi_cs_ni(cs_n),
    .spi_rx_i(mosi), .spi_tx_o(miso8), .rx_data_o(rx_data8),
    .rx_valid_o(rx_valid8), .rx_ready_i(rx_ready8), .tx_data_i(tx_data8),
    .tx_valid_i(tx_valid8), .tx_ready_o(tx_ready8), .frame_start_o(fs8),
    .frame_end_o(fe8), .rx_overflow_o(ovf8)
  );

  spi_word_target #(.WIDTH(16), .RX_DEPTH(4)) u_dut16 (
    .clk_sys_i(clk), .reset_i(rst), .spi_sck_i(sck), .spi_cs_ni(cs_n),
    .spi_rx_i(mosi), .spi_tx_o(miso16), .rx_data_o(rx_data16),
    .rx_valid_o(rx_valid16), .rx_ready_i(1'b1), .tx_data_i(tx_data16),
    .tx_valid_i(tx_valid16), .tx_ready_o(tx_ready16), .frame_start_o(fs16),
    .frame_end_o(fe16), .rx_overflow_o(ovf16)
  );

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_end = 0;
  logic [7:0] sb[$];
  logic model_ovf = 1'b0;
  logic [31:0] m8, m16;

`ifdef SPI_WORD_TARGET_ECHO_EN
  localparam logic [7:0] FILL_AFTER_FF = 8'hFF;
  localparam logic [7:0] ECHO_WORD2    = 8'h5A;
`else
  localparam logic [7:0] FILL_AFTER_FF = 8'h00;
  localparam logic [7:0] ECHO_WORD2    = 8'h00;
`endif

  typedef struct {
    logic       offer;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] miso;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every pop of the 8-bit target must match the model.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (fs8) n_start++;
      if (fe8) n_end++;
      if (rx_valid8 && rx_ready8) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected actual=%h required=none", rx_data8);
        end else begin
          e = sb.pop_front();
          chk("rx_pop", {24'd0, rx_data8}, {24'd0, e});
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_fall();
    @(negedge clk);
    cs_n = 1'b0;
    cyc(6);
  endtask

  task automatic cs_rise();
    cyc(4);
    cs_n = 1'b1;
    cyc(6);
  endtask

  task automatic xfer(input logic [31:0] d, input int n,
                      output logic [31:0] o8, output logic [31:0] o16);
    o8 = '0;
    o16 = '0;
    for (int i = 0; i < n; i++) begin
      mosi = d[n-1-i];
      cyc(4);
      o8  = {o8[30:0], miso8};
      o16 = {o16[30:0], miso16};
      sck = 1'b1;
      cyc(4);
      sck = 1'b0;
    end
  endtask

  task automatic expect_word(input logic [7:0] w);
    if (sb.size() < 4) sb.push_back(w);
    else model_ovf = 1'b1;
  endtask

  task automatic offer8(input logic [7:0] d);
    @(negedge clk);
    tx_data8 = d;
    tx_valid8 = 1'b1;
    @(negedge clk);
    tx_valid8 = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0] = '{1'b1, 8'hC3, 8'h5A, 8'hC3};
    vecs[1] = '{1'b1, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{1'b1, 8'h01, 8'hFF, 8'h01};
    vecs[3] = '{1'b0, 8'h00, 8'h81, FILL_AFTER_FF};

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    rx_ready8 = 1'b0; tx_valid8 = 1'b0; tx_data8 = '0;
    tx_valid16 = 1'b0; tx_data16 = '0;
    cyc(3);
    chk("rst_rx_valid", rx_valid8, 0);
    chk("rst_rx_data", rx_data8, 0);
    chk("rst_tx_ready", tx_ready8, 1);
    chk("rst_miso", miso8, 0);
    chk("rst_overflow", ovf8, 0);
    chk("rst_pulses", {fs8, fe8}, 0);
    rst = 1'b0;
    cyc(5);

    // 0xA5 with latency and frame-pulse checks
    expect_word(8'hA5);
    cs_fall();
    xfer(32'h52, 7, m8, m16);
    mosi = 1'b1;
    cyc(4);
    sck = 1'b1;
    lat = 0;
    while (!rx_valid8 && lat < 6) begin
      cyc(1);
      lat++;
    end
    chk("rx_valid_latency", {31'd0, rx_valid8 && (lat <= 4)}, 1);
    chk("rx_data_a5", rx_data8, 8'hA5);
    cyc(4);
    sck = 1'b0;
    cs_rise();
    chk("frame_start_count", n_start, 1);
    chk("frame_end_count", n_end, 1);
    rx_ready8 = 1'b1;
    cyc(3);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].offer) begin
        offer8(vecs[i].tx);
        chk("tx_ready_busy", tx_ready8, 0);
      end
      expect_word(vecs[i].mosi);
      cs_fall();
      chk("tx_ready_free", tx_ready8, 1);
      xfer({24'd0, vecs[i].mosi}, 8, m8, m16);
      chk("miso_vec", m8[7:0], vecs[i].miso);
      cs_rise();
    end

    // Fill word in the second word of a frame
    expect_word(8'h5A);
    expect_word(8'h00);
    cs_fall();
    xfer(32'h5A, 8, m8, m16);
    xfer(32'h00, 8, m8, m16);
    chk("miso_fill_word2", m8[7:0], ECHO_WORD2);
    cs_rise();

    // Partial word discarded on CS rise
    expect_word(8'h3C);
    cs_fall();
    xfer(32'h3C, 8, m8, m16);
    xfer(32'h16, 5, m8, m16);
    cs_rise();
    cyc(4);
    chk("sb_empty_partial", sb.size(), 0);

    // Overflow with the consumer stalled
    rx_ready8 = 1'b0;
    cs_fall();
    for (int w = 1; w <= 5; w++) begin
      expect_word(8'(w));
      xfer(32'(w), 8, m8, m16);
    end
    cs_rise();
    chk("overflow_set", ovf8, model_ovf);
    chk("overflow_head", rx_data8, 8'h01);
    rx_ready8 = 1'b1;
    cyc(8);
    chk("sb_empty_overflow", sb.size(), 0);
    chk("overflow_sticky", ovf8, 1);

    // 16-bit target transmits an offered word MSB-first
    @(negedge clk);
    tx_data16 = 16'h1234;
    tx_valid16 = 1'b1;
    @(negedge clk);
    tx_valid16 = 1'b0;
    chk("tx16_ready_busy", tx_ready16, 0);
    expect_word(8'hBE);
    expect_word(8'hEF);
    cs_fall();
    chk("tx16_ready_free", tx_ready16, 1);
    xfer(32'hBEEF, 16, m8, m16);
    chk("miso16_word", m16[15:0], 16'h1234);
    cs_rise();

    // Reset mid-word with CS low: rest of that frame ignored
    cs_fall();
    xfer(32'h5, 3, m8, m16);
    @(negedge clk);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk("midrst_overflow_clr", ovf8, 0);
    chk("midrst_rx_valid", rx_valid8, 0);
    xfer(32'h1F, 5, m8, m16);
    xfer(32'hFF, 8, m8, m16);
    cs_rise();
    cyc(4);
    chk("skip_no_word", rx_valid8, 0);
    expect_word(8'h77);
    cs_fall();
    xfer(32'h77, 8, m8, m16);
    cs_rise();

    cyc(10);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_word_target.md
SPI_WORD_TARGET -- requirements
Module: spi_word_target

Interface
- REQ-001 WIDTH, default 8, bits per SPI word (2..32).
- REQ-002 RX_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
- REQ-003 clk_sys_i  in  1  system clock; all logic in this domain.
- REQ-004 reset_i  in  1  synchronous, active-high reset.
- REQ-005 spi_sck_i  in  1  SPI clock, asynchronous, mode 0.
- REQ-006 spi_cs_ni  in  1  SPI chip select, active low, asynchronous.
- REQ-007 spi_rx_i  in  1  controller-to-target data (MOSI), asynchronous.
- REQ-008 spi_tx_o  out  1  target-to-controller data (MISO).
- REQ-009 rx_data_o  out  WIDTH  head of receive FIFO.
- REQ-010 rx_valid_o  out  1  FIFO not empty.
- REQ-011 rx_ready_i  in  1  consumer pops head when rx_valid_o && rx_ready_i.
- REQ-012 tx_data_i  in  WIDTH  next word to transmit.
- REQ-013 tx_valid_i  in  1  tx_data_i offered.
- REQ-014 tx_ready_o  out  1  tx holding register empty; accepts when tx_valid_i && tx_ready_o.
- REQ-015 frame_start_o / frame_end_o  out  1 each  single-cycle pulses on synchronized CS fall / rise.
- REQ-016 rx_overflow_o  out  1  sticky: word dropped because FIFO full.

Function
- REQ-017 spi_sck_i, spi_cs_ni, spi_rx_i SHALL each pass a 2-flop synchronizer, then a 1-flop edge detector; SCK high and low phases ≥ 3 clk_sys periods are guaranteed by the controller.
- REQ-018 State machine: IDLE (CS high), ARMED (CS low, bits counted), SKIP (CS low, frame not validly started); IDLE->ARMED on CS fall, ARMED->IDLE and SKIP->IDLE on CS rise.
- REQ-019 On CS fall: bit counters cleared, frame_start_o pulses, tx shift register loaded (REQ-022), spi_tx_o driven with its MSB.
- REQ-020 In ARMED, each SCK rise shifts spi_rx_i into the rx shift register MSB-first; the WIDTH-th rise completes a word and the counter wraps to 0.
- REQ-021 Completed word SHALL be written to the FIFO; rx_valid_o high exactly 1 clk_sys cycle after the write, i.e. ≤ 4 clk_sys cycles after the final raw SCK rise.
- REQ-022 Tx load: if holding register full, load it and free it (tx_ready_o rises next cycle); else load fill word (REQ-034/035).
- REQ-023 Each SCK fall in ARMED shifts tx register left, spi_tx_o = new MSB; on the WIDTH-th fall, tx register reloads per REQ-022 instead of shifting.
- REQ-024 FIFO full at word completion: word discarded, FIFO unchanged, rx_overflow_o set.
- REQ-025 Simultaneous pop and push: both occur in the same cycle; when full, no overflow.
- REQ-026 Pop when empty: ignored; pointers wrap modulo RX_DEPTH.
- REQ-027 CS rise mid-word: partial bits discarded, no FIFO write, frame_end_o pulses, tx holding register untouched.
- REQ-028 spi_tx_o SHALL be 0 whenever synchronized CS is high.
- REQ-029 SCK edges in IDLE or SKIP: ignored.

Reset
- REQ-030 While reset_i high: FIFO empty, rx_valid_o=0, rx_data_o=0, tx_ready_o=1, holding register empty, spi_tx_o=0, pulses=0, rx_overflow_o=0, counters=0, state IDLE.
- REQ-031 Synchronizer flops reset to CS=1, SCK=0, MOSI=0.
- REQ-032 If synchronized CS is low in the first cycle after reset release, state SHALL enter SKIP; no words received until CS rises and falls again.
- REQ-033 rx_overflow_o clears only on reset.

Configuration
- REQ-034 Macro SPI_WORD_TARGET_ECHO_EN defined: fill word = last word written to the FIFO (0 after reset).
- REQ-035 Macro undefined: fill word = all-zeros; no echo register implemented.

Verification
- REQ-036 WIDTH=8: CS low, send 0xA5 -> rx_data_o=0xA5, rx_valid_o=1 within 4 clk_sys of the 8th SCK rise; frame_start_o/frame_end_o pulse once each.
- REQ-037 WIDTH=16: tx 0x1234 accepted before CS fall -> MISO shows 0x1234 MSB-first; tx_ready_o high again next cycle after the CS-fall load.
- REQ-038 RX_DEPTH=4, rx_ready_i=0, send 5 words 0x01..0x05 -> FIFO holds 0x01..0x04, rx_overflow_o=1; pop order 0x01..0x04.
- REQ-039 Send 0x3C then 5 bits, raise CS -> one FIFO entry 0x3C only.
- REQ-040 ECHO_EN, no tx offered: send 0x5A then 0x00 in one frame -> MISO word 2 = 0x5A; without macro -> 0x00.
- REQ-041 Assert reset_i mid-word with CS low, release -> SKIP; remaining bits ignored; next CS-low frame with 0x77 -> rx_data_o=0x77.
